// File: rtl/debounce_bank.sv
// debounce_bank: N-channel button conditioner with debounced levels and press/release/long-press strobes.
// Define DEBOUNCE_REPEAT_EN to re-pulse pressed every REPEAT_CYCLES after a long press.
module debounce_bank #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned CNT           = 21,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] long_press,
    output logic                any_event
);
    localparam bit            HOLD_EN   = (HOLD_CYCLES != 0);
    localparam bit            REP_EN    = HOLD_EN && (REPEAT_CYCLES != 0);
    localparam int unsigned   HW        = HOLD_EN ? $clog2(64'(HOLD_CYCLES) + 64'd1) : 1;
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic           s1, s2, st, pr, rl, lp;
        logic [CNT-1:0] cnt;
        logic [HW-1:0]  hc;
        logic           p, accept, rise, fall, lp_d, rep_hit, rep;

        assign p      = s2 ^ ACTIVE_LOW;
        assign accept = cnt[CNT-1] && (p != st);
        assign rise   = accept && p;
        assign fall   = accept && !p;
        // A release landing on the threshold cycle wins; no long press for that hold.
        assign lp_d   = HOLD_EN && st && !fall && (hc == HOLD_LAST);
        assign rep    = REP_EN && rep_hit && st && !fall;

        // Synchroniser idles at the released pin level so reset release is silent.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1  <= ACTIVE_LOW;
                s2  <= ACTIVE_LOW;
                cnt <= '0;
                st  <= 1'b0;
                pr  <= 1'b0;
                rl  <= 1'b0;
            end else begin
                s1 <= btn[i];
                s2 <= s1;
                if (s1 != s2) begin
                    cnt <= '0;
                end else if (!cnt[CNT-1]) begin
                    cnt <= cnt + CNT'(1);
                end
                if (accept) begin
                    st <= p;
                end
                pr <= rise || rep;
                rl <= fall;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hc <= '0;
                lp <= 1'b0;
            end else begin
                lp <= lp_d;
                if (!st || !HOLD_EN) begin
                    hc <= '0;
                end else if (hc != HOLD_MAX) begin
                    hc <= hc + HW'(1);
                end
            end
        end

`ifdef DEBOUNCE_REPEAT_EN
        localparam int unsigned   RW       = (REPEAT_CYCLES != 0) ? $clog2(64'(REPEAT_CYCLES) + 64'd1) : 1;
        localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
        logic          armed;
        logic [RW-1:0] rc;

        assign rep_hit = armed && (rc == REP_LAST);

        // Armed by the long-press cycle, disarmed by release.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                armed <= 1'b0;
                rc    <= '0;
            end else if (!st || fall) begin
                armed <= 1'b0;
                rc    <= '0;
            end else if (lp_d) begin
                armed <= 1'b1;
                rc    <= '0;
            end else if (armed) begin
                rc <= rep_hit ? '0 : rc + RW'(1);
            end
        end
`else
        assign rep_hit = 1'b0;
`endif

        assign state[i]      = st;
        assign pressed[i]    = pr;
        assign released[i]   = rl;
        assign long_press[i] = lp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_event <= 1'b0;
        end else begin
            any_event <= |{pressed, released, long_press};
        end
    end
endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: timestamp-based reference model feeding a scoreboard queue,
// plus directed latency checks; works with or without DEBOUNCE_REPEAT_EN.
module tb_debounce_bank;
    localparam int CH     = 4;
    localparam int CNT    = 4;
    localparam int HOLD   = 20;
    localparam int RPT    = 8;
    localparam bit AL     = 1'b1;
    localparam int STABLE = (1 << (CNT - 1)) + 1;
    localparam int HLEN   = STABLE + 2;
    localparam int W      = 4 * CH + 1;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] btn = {CH{AL}};
    logic [CH-1:0] state, pressed, released, long_press;
    logic          any_event;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [W-1:0]  exp_q[$];

    debounce_bank #(
        .CHANNELS(CH), .CNT(CNT), .ACTIVE_LOW(AL),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .state(state), .pressed(pressed),
        .released(released), .long_press(long_press), .any_event(any_event)
    );

    always #5 clk = ~clk;

    // Reference model: levels in pressed-polarity, last HLEN pin samples, event timestamps.
    logic [CH-1:0] hist[$];
    logic [CH-1:0] m_state;
    int            t_press[CH];
    int            t_lp[CH];
    logic          prev_any;
    int            cyc = 0;

    always @(posedge clk) begin : model
        logic [CH-1:0] lv, h, e_p, e_r, e_l;
        logic          v, stable;
        cyc++;
        e_p = '0;
        e_r = '0;
        e_l = '0;
        if (!rst) begin
            hist.delete();
            for (int j = 0; j < HLEN; j++) hist.push_back('0);
            m_state  = '0;
            prev_any = 1'b0;
            for (int c = 0; c < CH; c++) begin
                t_press[c] = 0;
                t_lp[c]    = -1;
            end
            exp_q.push_back('0);
        end else begin
            lv = btn ^ {CH{AL}};
            hist.push_back(lv);
            void'(hist.pop_front());
            for (int c = 0; c < CH; c++) begin
                // Accept a level held for STABLE samples, seen two samples late through the synchroniser.
                h = hist[STABLE - 1];
                v = h[c];
                stable = 1'b1;
                for (int j = 0; j < STABLE; j++) begin
                    h = hist[j];
                    if (h[c] != v) stable = 1'b0;
                end
                if (stable && v && !m_state[c]) begin
                    e_p[c] = 1'b1;
                    m_state[c] = 1'b1;
                    t_press[c] = cyc;
                    t_lp[c] = -1;
                end else if (stable && !v && m_state[c]) begin
                    e_r[c] = 1'b1;
                    m_state[c] = 1'b0;
                    t_lp[c] = -1;
                end else if (m_state[c]) begin
                    if (HOLD > 0 && cyc == t_press[c] + HOLD) begin
                        e_l[c] = 1'b1;
                        t_lp[c] = cyc;
                    end else if (REP && HOLD > 0 && RPT > 0 && t_lp[c] >= 0 &&
                                 cyc > t_lp[c] && (cyc - t_lp[c]) % RPT == 0) begin
                        e_p[c] = 1'b1;
                    end
                end
            end
            exp_q.push_back({m_state, e_p, e_r, e_l, prev_any});
            prev_any = |{e_p, e_r, e_l};
        end
    end

    // Monitor: every cycle the DUT presents a full output vector; pop one expectation per cycle.
    always @(negedge clk) begin : monitor
        logic [W-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, pressed, released, long_press, any_event};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t got st=%b pr=%b rl=%b lp=%b any=%b want st=%b pr=%b rl=%b lp=%b any=%b",
                         $time, a[4*CH -: CH], a[3*CH -: CH], a[2*CH -: CH], a[CH -: CH], a[0],
                         e[4*CH -: CH], e[3*CH -: CH], e[2*CH -: CH], e[CH -: CH], e[0]);
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [CH-1:0] v);
        @(negedge clk);
        btn = v;
    endtask

    initial begin : watchdog
        #1000000;
        n_bad++;
        $display("FAIL watchdog time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin : stimulus
        logic [CH-1:0] v;
        repeat (3) @(negedge clk);
        check("reset_outputs", W'({state, pressed, released, long_press, any_event}), W'(0));
        rst = 1'b1;
        idle(15);

        // Clean press on ch0: strobe 10 cycles after the change is sampled.
        drive(4'b1110);
        repeat (10) @(negedge clk);
        check("press_before_latency", W'({state, pressed}), W'(0));
        @(negedge clk);
        check("press_state", W'(state), W'(4'b0001));
        check("press_strobe", W'(pressed), W'(4'b0001));
        @(negedge clk);
        check("press_any_event", W'(any_event), W'(1));
        check("press_single_cycle", W'(pressed), W'(0));
        idle(20);
        drive(4'b1111);
        idle(15);

        // Bounce on ch1 every 3 cycles, then settle low.
        for (int i = 0; i < 12; i++) begin
            drive(btn ^ 4'b0010);
            idle(2);
        end
        drive(4'b1101);
        repeat (10) @(negedge clk);
        check("bounce_no_early_state", W'(state), W'(0));
        @(negedge clk);
        check("bounce_single_press", W'(pressed), W'(4'b0010));
        idle(40);
        drive(4'b1111);
        idle(15);

        // Long press on ch2: long_press exactly HOLD cycles after pressed.
        drive(4'b1011);
        repeat (30) @(negedge clk);
        check("long_not_early", W'(long_press), W'(0));
        @(negedge clk);
        check("long_at_hold", W'(long_press), W'(4'b0100));
        idle(30);
        drive(4'b1111);
        idle(15);
        // Short hold on ch2: no long_press, released after the latency.
        drive(4'b1011);
        idle(26);
        drive(4'b1111);
        repeat (11) @(negedge clk);
        check("short_release", W'(released), W'(4'b0100));
        idle(15);

        // Simultaneous press ch0 and release ch3.
        drive(4'b0111);
        idle(15);
        drive(4'b1110);
        repeat (11) @(negedge clk);
        check("simul_strobes", W'({pressed, released}), W'({4'b0001, 4'b1000}));
        @(negedge clk);
        check("simul_any_event", W'(any_event), W'(1));
        @(negedge clk);
        check("simul_any_single", W'(any_event), W'(0));
        drive(4'b1111);
        idle(15);

        // Reset mid-hold on ch1, held through reset release.
        drive(4'b1101);
        idle(15);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("reset_immediate", W'({state, pressed, released, long_press, any_event}), W'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_held_early", W'(state), W'(0));
        @(negedge clk);
        check("reset_held_press", W'(pressed), W'(4'b0010));
        drive(4'b1111);
        idle(15);
        // Reset with idle pins: scoreboard expects silence afterwards.
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(15);

        // Randomised segments: mixed glitches, short and long holds, one reset in the middle.
        for (int s = 0; s < 300; s++) begin
            v = btn;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 2) == 0) v[c] = ~v[c];
            end
            drive(v);
            idle($urandom_range(0, 40));
            if (s == 150) begin
                @(negedge clk);
                #2 rst = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
            end
        end

        drive({CH{AL}});
        idle(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Multi-channel button/switch conditioner: N independent debounced channels with registered level outputs and one-cycle event strobes (press, release, long-press).
- Generalises the single-channel debouncer with parametrised channel count, input polarity, long-press detection and an aggregate event flag.
- Sits between board pins (front-panel buttons, footswitches) and the MIDI control logic.
- Event outputs feed the control FSMs directly; no further edge detection is needed downstream.

Parameters:
- CHANNELS, 4, number of independent input channels (1..32).
- CNT, 21, stability counter width; input must be stable for 2^(CNT-1) cycles before it is accepted (2^20 cycles at 100 MHz is about 10 ms).
- ACTIVE_LOW, 1, 1 = pin low means pressed (pulled-up buttons); 0 = pin high means pressed.
- HOLD_CYCLES, 50000000, cycles of debounced press before long_press fires; 0 disables long-press.
- REPEAT_CYCLES, 10000000, auto-repeat period; used only with DEBOUNCE_REPEAT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- btn  input  CHANNELS  raw asynchronous pin levels.
- state  output  CHANNELS  debounced level; 1 = pressed, polarity already applied.
- pressed  output  CHANNELS  one-cycle strobe when a press is accepted.
- released  output  CHANNELS  one-cycle strobe when a release is accepted.
- long_press  output  CHANNELS  one-cycle strobe when the hold threshold is reached.
- any_event  output  1  registered OR of pressed, released and long_press over all channels.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low. It clears all state, counters and outputs to 0. Synchroniser flops reset to the idle pin level (1 if ACTIVE_LOW, else 0) so reset release produces no spurious event.
- Per-channel datapath:
  - Two-flop synchroniser s1 then s2.
  - Polarity is applied after s2, giving p = s2 XOR ACTIVE_LOW.
  - Stability counter cnt[CNT-1:0] clears to 0 on any cycle where s1 != s2.
  - Otherwise cnt increments while cnt[CNT-1] == 0 and holds once the MSB is set (it saturates and does not wrap).
  - When cnt[CNT-1] == 1 and p != state, state loads p.
- Press and release strobes:
  - pressed is asserted in exactly the cycle state first reads 1.
  - released is asserted in exactly the cycle state first reads 0.
  - Both are registered in the same clock edge that updates state.
- Latency: a pin change sampled at edge E0 that stays stable appears on state and pressed/released at edge E0 + 2^(CNT-1) + 2.
  - Example: CNT = 4 gives 10 cycles.
  - Any pulse or glitch shorter than 2^(CNT-1) + 1 cycles produces no change and no strobe.
- Hold counter: hold counter hc (width $clog2(HOLD_CYCLES+1), minimum 1) behaves as follows.
  - It is 0 while state == 0.
  - It increments each cycle while state == 1 and saturates at HOLD_CYCLES.
  - long_press pulses once, in the cycle hc becomes HOLD_CYCLES.
  - That cycle is HOLD_CYCLES cycles after the pressed strobe.
  - Release before the threshold: no long_press.
  - Exactly one long_press per press.
- Channels are fully independent. Simultaneous events on different channels all strobe in the same cycle. pressed and released are never both set for the same channel in the same cycle.
- any_event is registered and lags the per-channel strobes by one cycle. It is a single-cycle pulse per cycle that has at least one strobe.
- Reset mid-operation: everything clears immediately.
  - If a button is held through reset release, state starts at 0.
  - pressed then fires 2^(CNT-1) + 2 cycles after reset deassertion. A button held through reset is therefore reported as a fresh press.
- Counter widths must not overflow. Comparisons are done at full width, and there is no truncation of HOLD_CYCLES or REPEAT_CYCLES.

Optional Feature:
- Macro name: DEBOUNCE_REPEAT_EN.
- With the macro defined (auto-repeat):
  - After long_press fires on a channel, pressed re-pulses on that channel every REPEAT_CYCLES cycles while state == 1.
  - The first repeat occurs REPEAT_CYCLES cycles after the long_press cycle.
  - The repeat counter clears on release; no further repeats after released.
  - REPEAT_CYCLES == 0 or HOLD_CYCLES == 0 disables repeat.
- Without the macro: pressed fires exactly once per accepted press, and the repeat counter logic is absent from the netlist.

Test Plan:
- Clean press, CHANNELS = 4, CNT = 4, ACTIVE_LOW = 1: drive btn[0] 1 -> 0 at E0 and hold -> state[0] = 1 and a 1-cycle pressed[0] at E0 + 10; any_event at E0 + 11; other channels stay 0.
- Bounce rejection: toggle btn[1] every 3 cycles for 40 cycles, then hold low -> no strobes during bouncing; a single pressed[1] arrives 10 cycles after the last toggle.
- Long press, HOLD_CYCLES = 20: hold btn[2] low for 50 cycles after acceptance -> long_press[2] exactly 20 cycles after pressed[2], once. Hold only 15 cycles -> no long_press, and released[2] fires after the release latency.
- Simultaneous events: press ch0 and release ch3 in the same cycle -> pressed[0] and released[3] in the same cycle; a single any_event pulse one cycle later.
- Reset: assert rst low mid-hold on ch1 -> all outputs 0 immediately. Deassert with the button still held -> pressed[1] 10 cycles later. No event if pins are idle at reset release.
- DEBOUNCE_REPEAT_EN, HOLD_CYCLES = 20, REPEAT_CYCLES = 8: hold ch0 for 60 cycles -> pressed at t0, long_press at t0 + 20, pressed at t0 + 28, t0 + 36, t0 + 44, …; no pressed after released. Without the macro: pressed at t0 only.
